// File: rtl/m_axi_read_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// m_axi_read_arbiter_pkg
//   Shared definitions for the AXI4-Lite read-port arbiter: AXI RRESP codes
//   and the transaction FSM state encoding.
// -----------------------------------------------------------------------------
package m_axi_read_arbiter_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } state_t;

endpackage

// File: rtl/m_axi_read_arbiter_rr.sv
// -----------------------------------------------------------------------------
// rr_arbiter_comb
//   Purely combinational round-robin pick. Scans last_grant+1, last_grant+2, ...
//   modulo NUM_REQ and returns the first requester with req_valid set.
// Ports:
//   req_valid  - per-requester request
//   last_grant - index granted most recently
//   winner     - selected index (0 when none valid)
//   any_valid  - at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter_comb
  import m_axi_read_arbiter_pkg::*;
#(
  parameter int NUM_REQ       = 2,
  parameter int REQ_IDX_WIDTH = 1
) (
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [REQ_IDX_WIDTH-1:0] last_grant,
  output logic [REQ_IDX_WIDTH-1:0] winner,
  output logic                     any_valid
);

  logic                     w_found;
  logic [REQ_IDX_WIDTH-1:0] w_idx;

  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    winner  = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      w_idx = REQ_IDX_WIDTH'((32'(last_grant) + k) % NUM_REQ);
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        winner  = w_idx;
      end
    end
  end

  assign any_valid = |req_valid;

endmodule

// File: rtl/m_axi_read_arbiter.sv
// -----------------------------------------------------------------------------
// m_axi_read_arbiter
//   Shares one AXI4-Lite read master among NUM_REQ requesters, round-robin,
//   one outstanding read at a time (IDLE -> ADDR -> DATA -> RESP).
// Ports:
//   clk, reset (async, active low)
//   req_valid/req_addr/req_ready   - requester side, req_ready one-hot in IDLE
//   rsp_valid/rsp_ready            - one-hot response slot for the grantee
//   rsp_data/rsp_resp              - shared, held from the last read
//   busy                           - any state other than IDLE
//   err_cnt                        - saturating count of non-OKAY RRESP
//   M_AXI_AR*/M_AXI_R*             - AXI4-Lite read channels
// -----------------------------------------------------------------------------
module m_axi_read_arbiter
  import m_axi_read_arbiter_pkg::*;
#(
  parameter int NUM_REQ         = 2,
  parameter int REQ_IDX_WIDTH   = 1,
  parameter int GLOB_ADDR_WIDTH = 32,
  parameter int GLOB_DATA_WIDTH = 32,
  parameter int ERR_CNT_WIDTH   = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_REQ-1:0]                 req_valid,
  input  logic [NUM_REQ*GLOB_ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]                 req_ready,
  output logic [NUM_REQ-1:0]                 rsp_valid,
  input  logic [NUM_REQ-1:0]                 rsp_ready,
  output logic [GLOB_DATA_WIDTH-1:0]         rsp_data,
  output logic [1:0]                         rsp_resp,
  output logic                               busy,
  output logic [ERR_CNT_WIDTH-1:0]           err_cnt,
  output logic [GLOB_ADDR_WIDTH-1:0]         M_AXI_ARADDR,
  output logic                               M_AXI_ARVALID,
  input  logic                               M_AXI_ARREADY,
  input  logic [GLOB_DATA_WIDTH-1:0]         M_AXI_RDATA,
  input  logic [1:0]                         M_AXI_RRESP,
  input  logic                               M_AXI_RVALID,
  output logic                               M_AXI_RREADY
);

  state_t                     r_state;
  logic [REQ_IDX_WIDTH-1:0]   r_last_grant;
  logic [REQ_IDX_WIDTH-1:0]   r_grant_idx;
  logic [GLOB_ADDR_WIDTH-1:0] r_addr;
  logic [GLOB_DATA_WIDTH-1:0] r_data;
  logic [1:0]                 r_resp;
  logic [ERR_CNT_WIDTH-1:0]   r_err_cnt;
  logic                       r_arvalid;
  logic                       r_rready;
  logic [NUM_REQ-1:0]         r_rsp_valid;

  logic [REQ_IDX_WIDTH-1:0]   w_winner;
  logic                       w_any_valid;
  logic [GLOB_ADDR_WIDTH-1:0] w_sel_addr;

  rr_arbiter_comb #(
    .NUM_REQ       (NUM_REQ),
    .REQ_IDX_WIDTH (REQ_IDX_WIDTH)
  ) u_rr (
    .req_valid  (req_valid),
    .last_grant (r_last_grant),
    .winner     (w_winner),
    .any_valid  (w_any_valid)
  );

  assign w_sel_addr = req_addr[w_winner*GLOB_ADDR_WIDTH +: GLOB_ADDR_WIDTH];

  // Accept is combinational so a waiting requester is taken in the same cycle.
  assign req_ready = (r_state == ST_IDLE && w_any_valid) ? (NUM_REQ'(1) << w_winner) : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_last_grant <= REQ_IDX_WIDTH'(NUM_REQ - 1);
      r_grant_idx  <= '0;
      r_addr       <= '0;
      r_data       <= '0;
      r_resp       <= '0;
      r_err_cnt    <= '0;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_rsp_valid  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_valid) begin
            r_addr      <= w_sel_addr;
            r_grant_idx <= w_winner;
            r_arvalid   <= 1'b1;
            r_state     <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (M_AXI_ARREADY) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (M_AXI_RVALID) begin
            r_rready    <= 1'b0;
            r_data      <= M_AXI_RDATA;
            r_resp      <= M_AXI_RRESP;
            r_rsp_valid <= NUM_REQ'(1) << r_grant_idx;
            if (M_AXI_RRESP != RESP_OKAY && r_err_cnt != '1) begin
              r_err_cnt <= r_err_cnt + ERR_CNT_WIDTH'(1);
            end
            r_state <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready[r_grant_idx]) begin
            r_rsp_valid  <= '0;
            r_last_grant <= r_grant_idx;
            r_state      <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rsp_valid     = r_rsp_valid;
  assign rsp_data      = r_data;
  assign rsp_resp      = r_resp;
  assign busy          = (r_state != ST_IDLE);
  assign err_cnt       = r_err_cnt;
  assign M_AXI_ARADDR  = r_addr;
  assign M_AXI_ARVALID = r_arvalid;
  assign M_AXI_RREADY  = r_rready;

endmodule
